// File: rtl/cpu_pkg.sv
// Shared opcode/funct encodings and immediate-extension modes for the MIPS pipeline.
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'd0,
        EXT_ZERO  = 2'd1,
        EXT_UPPER = 2'd2
    } ext_mode_t;

    // Extension mode used by an opcode's 16-bit immediate field.
    function automatic ext_mode_t ext_for_op(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return EXT_ZERO;
            OP_LUI:                   return EXT_UPPER;
            default:                  return EXT_SIGN;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Architectural register file: two read ports with write-through bypass, one write port, r0 fixed at 0.
module regfile #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b
);

    localparam int unsigned DEPTH = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_en;

    assign wr_en = we && (waddr != '0);

    // Storage update; r0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports forward a same-cycle write so ID sees the value WB is retiring.
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
        if (wr_en && (raddr_a == waddr)) rdata_a = wdata;
        if (wr_en && (raddr_b == waddr)) rdata_b = wdata;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register file, instruction decode, immediate extension, load-use hazard and ID/EX register.
module id_stage_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [31:0]           ins,
    input  logic [DATA_W-1:0]     npc_i,
    input  logic                  flush,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0]     write_data,
    output logic                  id_stall,
    output logic                  out_valid,
    output logic                  if_reg_write,
    output logic                  if_mem_read,
    output logic                  if_mem_write,
    output logic [5:0]            op,
    output logic [5:0]            func,
    output logic [DATA_W-1:0]     data_a,
    output logic [DATA_W-1:0]     data_b,
    output logic [REG_ADDR_W-1:0] data_write_reg,
    output logic [DATA_W-1:0]     imm,
    output logic [25:0]           jpc,
    output logic [DATA_W-1:0]     npc_o
);

    logic [5:0]            dec_op;
    logic [REG_ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0]     rf_a, rf_b;

    logic                  d_wr, d_rd_mem, d_wr_mem;
    logic                  d_use_rs, d_use_rt, d_has_imm, d_is_jump, d_is_rtype;
    logic [REG_ADDR_W-1:0] d_dst;
    logic [DATA_W-1:0]     d_imm;
    logic                  hit_rs, hit_rt;

    assign dec_op = ins[31:26];
    assign rs     = REG_ADDR_W'(ins[25:21]);
    assign rt     = REG_ADDR_W'(ins[20:16]);
    assign rd     = REG_ADDR_W'(ins[15:11]);

    regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (reg_write),
        .waddr   (write_reg),
        .wdata   (write_data),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // Opcode decode into enables, destination and source usage; unknown opcodes become NOPs.
    always_comb begin
        d_wr       = 1'b0;
        d_rd_mem   = 1'b0;
        d_wr_mem   = 1'b0;
        d_dst      = '0;
        d_use_rs   = 1'b1;
        d_use_rt   = 1'b0;
        d_has_imm  = 1'b0;
        d_is_jump  = 1'b0;
        d_is_rtype = 1'b0;
        case (dec_op)
            OP_SPECIAL: begin
                d_wr       = 1'b1;
                d_dst      = rd;
                d_use_rt   = 1'b1;
                d_is_rtype = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                d_wr      = 1'b1;
                d_dst     = rt;
                d_has_imm = 1'b1;
            end
            OP_LW, OP_LB: begin
                d_wr      = 1'b1;
                d_rd_mem  = 1'b1;
                d_dst     = rt;
                d_has_imm = 1'b1;
            end
            OP_SW, OP_SB: begin
                d_wr_mem  = 1'b1;
                d_use_rt  = 1'b1;
                d_has_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d_use_rt  = 1'b1;
                d_has_imm = 1'b1;
            end
            OP_BGTZ: begin
                d_has_imm = 1'b1;
            end
            OP_J: begin
                d_use_rs  = 1'b0;
                d_is_jump = 1'b1;
            end
            OP_JAL: begin
                d_wr      = 1'b1;
                d_dst     = REG_ADDR_W'(LINK_REG);
                d_use_rs  = 1'b0;
                d_is_jump = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate extension; formats without an immediate pass 0.
    always_comb begin
        d_imm = '0;
        if (d_has_imm) begin
            case (ext_for_op(dec_op))
                EXT_ZERO:  d_imm = DATA_W'(ins[15:0]);
                EXT_UPPER: d_imm = DATA_W'({ins[15:0], 16'h0000});
                default:   d_imm = DATA_W'($signed(ins[15:0]));
            endcase
        end
    end

    // Load in the EX slot whose destination feeds a source actually read by the ID instruction.
    assign hit_rs   = d_use_rs && (rs == data_write_reg);
    assign hit_rt   = d_use_rt && (rt == data_write_reg);
    assign id_stall = in_valid && !flush && out_valid && if_mem_read &&
                      (data_write_reg != '0) && (hit_rs || hit_rt);

    // ID/EX pipeline register: flush, stall and empty input all load a zeroed bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            if_reg_write   <= 1'b0;
            if_mem_read    <= 1'b0;
            if_mem_write   <= 1'b0;
            op             <= '0;
            func           <= '0;
            data_a         <= '0;
            data_b         <= '0;
            data_write_reg <= '0;
            imm            <= '0;
            jpc            <= '0;
            npc_o          <= '0;
        end else if (flush || id_stall || !in_valid) begin
            out_valid      <= 1'b0;
            if_reg_write   <= 1'b0;
            if_mem_read    <= 1'b0;
            if_mem_write   <= 1'b0;
            op             <= '0;
            func           <= '0;
            data_a         <= '0;
            data_b         <= '0;
            data_write_reg <= '0;
            imm            <= '0;
            jpc            <= '0;
            npc_o          <= '0;
        end else begin
            out_valid      <= 1'b1;
            if_reg_write   <= d_wr;
            if_mem_read    <= d_rd_mem;
            if_mem_write   <= d_wr_mem;
            op             <= dec_op;
            func           <= d_is_rtype ? ins[5:0] : 6'd0;
            data_a         <= d_use_rs ? rf_a : '0;
            data_b         <= d_use_rt ? rf_b : '0;
            data_write_reg <= d_dst;
            imm            <= d_imm;
            jpc            <= d_is_jump ? ins[25:0] : 26'd0;
            npc_o          <= npc_i;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] ins;
    logic [31:0] npc_i;
    logic        flush;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        id_stall;
    logic        out_valid;
    logic        if_reg_write, if_mem_read, if_mem_write;
    logic [5:0]  op, func;
    logic [31:0] data_a, data_b;
    logic [4:0]  data_write_reg;
    logic [31:0] imm;
    logic [25:0] jpc;
    logic [31:0] npc_o;

    int checks = 0;
    int errors = 0;

    id_stage_pipe #(
        .DATA_W     (32),
        .REG_ADDR_W (5),
        .LINK_REG   (31)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .ins            (ins),
        .npc_i          (npc_i),
        .flush          (flush),
        .reg_write      (reg_write),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .id_stall       (id_stall),
        .out_valid      (out_valid),
        .if_reg_write   (if_reg_write),
        .if_mem_read    (if_mem_read),
        .if_mem_write   (if_mem_write),
        .op             (op),
        .func           (func),
        .data_a         (data_a),
        .data_b         (data_b),
        .data_write_reg (data_write_reg),
        .imm            (imm),
        .jpc            (jpc),
        .npc_o          (npc_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; ins = '0; npc_i = '0; flush = 1'b0;
        reg_write = 1'b0; write_reg = '0; write_data = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", out_valid); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", id_stall); end
        checks++; if (imm !== 32'h0) begin errors++; $display("FAIL reset_imm: got %h want 0", imm); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_immediates();
        ins = 32'h2001FFFB; npc_i = 32'h104; in_valid = 1'b1;  // ADDI r1,r0,-5
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %0h want 1", out_valid); end
        checks++; if (if_reg_write !== 1'b1) begin errors++; $display("FAIL addi_wr: got %0h want 1", if_reg_write); end
        checks++; if (data_write_reg !== 5'd1) begin errors++; $display("FAIL addi_dst: got %0d want 1", data_write_reg); end
        checks++; if (imm !== 32'hFFFFFFFB) begin errors++; $display("FAIL addi_imm: got %h want fffffffb", imm); end
        checks++; if (op !== 6'h08) begin errors++; $display("FAIL addi_op: got %h want 08", op); end
        ins = 32'h34028001;  // ORI r2,r0,0x8001
        step();
        checks++; if (imm !== 32'h00008001) begin errors++; $display("FAIL ori_imm: got %h want 00008001", imm); end
        checks++; if (data_write_reg !== 5'd2) begin errors++; $display("FAIL ori_dst: got %0d want 2", data_write_reg); end
        ins = 32'h3C031234;  // LUI r3,0x1234
        step();
        checks++; if (imm !== 32'h12340000) begin errors++; $display("FAIL lui_imm: got %h want 12340000", imm); end
        ins = 32'hAC220008;  // SW r2,8(r1)
        step();
        checks++; if (if_mem_write !== 1'b1 || if_reg_write !== 1'b0) begin errors++; $display("FAIL sw_en: got mw=%0h rw=%0h want mw=1 rw=0", if_mem_write, if_reg_write); end
        checks++; if (imm !== 32'h8 || data_write_reg !== 5'd0) begin errors++; $display("FAIL sw_fields: got imm=%h dst=%0d want imm=8 dst=0", imm, data_write_reg); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble: got %0h want 0", out_valid); end
    endtask

    task automatic test_regfile();
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEADBEEF;
        ins = 32'h00A03020; in_valid = 1'b1;  // ADD r6,r5,r0
        step();
        checks++; if (data_a !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_a: got %h want deadbeef", data_a); end
        checks++; if (func !== 6'h20 || data_write_reg !== 5'd6) begin errors++; $display("FAIL add_fields: got func=%h dst=%0d want 20/6", func, data_write_reg); end
        reg_write = 1'b0;
        ins = 32'h00A53820;  // ADD r7,r5,r5
        step();
        checks++; if (data_a !== 32'hDEADBEEF || data_b !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_r5: got a=%h b=%h want deadbeef", data_a, data_b); end
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h00001234;
        ins = 32'h00004020;  // ADD r8,r0,r0
        step();
        checks++; if (data_a !== 32'h0) begin errors++; $display("FAIL r0_nobypass: got %h want 0", data_a); end
        reg_write = 1'b0;
        step();
        checks++; if (data_a !== 32'h0 || data_b !== 32'h0) begin errors++; $display("FAIL r0_read: got a=%h b=%h want 0", data_a, data_b); end
    endtask

    task automatic test_load_use();
        ins = 32'h8C240000;  // LW r4,0(r1)
        step();
        checks++; if (if_mem_read !== 1'b1 || data_write_reg !== 5'd4) begin errors++; $display("FAIL lw_slot: got mr=%0h dst=%0d want 1/4", if_mem_read, data_write_reg); end
        ins = 32'h00843820;  // ADD r7,r4,r4
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0h want 1", id_stall); end
        step();
        checks++; if (out_valid !== 1'b0 || if_mem_read !== 1'b0) begin errors++; $display("FAIL lu_bubble: got v=%0h mr=%0h want 0", out_valid, if_mem_read); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop: got %0h want 0", id_stall); end
        step();
        checks++; if (out_valid !== 1'b1 || data_write_reg !== 5'd7) begin errors++; $display("FAIL lu_issue: got v=%0h dst=%0d want 1/7", out_valid, data_write_reg); end
        ins = 32'h8C240000;  // LW r4,0(r1)
        step();
        ins = 32'h20040001;  // ADDI r4,r0,1
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rt_unused_stall: got %0h want 0", id_stall); end
        step();
        checks++; if (out_valid !== 1'b1 || data_write_reg !== 5'd4) begin errors++; $display("FAIL rt_unused_issue: got v=%0h dst=%0d want 1/4", out_valid, data_write_reg); end
    endtask

    task automatic test_flush_jal();
        ins = 32'h8C240000;  // LW r4,0(r1)
        step();
        ins = 32'h00843820;  // ADD r7,r4,r4
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL fl_pre_stall: got %0h want 1", id_stall); end
        flush = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL fl_stall_forced: got %0h want 0", id_stall); end
        step();
        checks++; if (out_valid !== 1'b0 || if_reg_write !== 1'b0) begin errors++; $display("FAIL fl_bubble: got v=%0h rw=%0h want 0", out_valid, if_reg_write); end
        flush = 1'b0;
        ins = 32'h0C000123; npc_i = 32'h00002008;  // JAL 0x123
        step();
        checks++; if (data_write_reg !== 5'd31 || if_reg_write !== 1'b1) begin errors++; $display("FAIL jal_dst: got dst=%0d rw=%0h want 31/1", data_write_reg, if_reg_write); end
        checks++; if (npc_o !== 32'h00002008 || jpc !== 26'h123) begin errors++; $display("FAIL jal_pc: got npc=%h jpc=%h want 2008/123", npc_o, jpc); end
    endtask

    task automatic test_reset_mid();
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h00000055;
        in_valid = 1'b0;
        step();
        reg_write = 1'b0;
        ins = 32'h01295020; in_valid = 1'b1;  // ADD r10,r9,r9
        step();
        checks++; if (data_a !== 32'h55) begin errors++; $display("FAIL pre_reset_r9: got %h want 55", data_a); end
        ins = 32'h8C240000;  // LW r4,0(r1)
        step();
        ins = 32'h00843820;  // ADD r7,r4,r4
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %0h want 1", id_stall); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || if_mem_read !== 1'b0 || data_write_reg !== 5'd0) begin errors++; $display("FAIL mid_rst_ctl: got v=%0h mr=%0h dst=%0d want 0", out_valid, if_mem_read, data_write_reg); end
        checks++; if (imm !== 32'h0 || npc_o !== 32'h0 || op !== 6'h0) begin errors++; $display("FAIL mid_rst_data: got imm=%h npc=%h op=%h want 0", imm, npc_o, op); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %0h want 0", id_stall); end
        #3;
        rst_n = 1'b1;
        ins = 32'h01295020;  // ADD r10,r9,r9
        step();
        checks++; if (out_valid !== 1'b1 || data_a !== 32'h0 || data_b !== 32'h0) begin errors++; $display("FAIL post_reset_r9: got v=%0h a=%h b=%h want 1/0/0", out_valid, data_a, data_b); end
    endtask

    initial begin
        test_reset();
        test_immediates();
        test_regfile();
        test_load_use();
        test_flush_jal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the 5-stage MIPS pipeline, sitting between IF and EX. It owns the architectural register file, decodes the instruction, and selects sign-, zero- or upper-extended immediates. It detects load-use hazards, stalling IF and inserting a bubble, and honours a branch flush. All EX-facing outputs are registered, so the block contains the ID/EX pipeline register.

## Interface
- `DATA_W`, 32, datapath and register width
- `REG_ADDR_W`, 5, register index width; the file holds 2^REG_ADDR_W registers
- `LINK_REG`, 31, JAL destination index
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1: `ins`/`npc_i` hold a real instruction
- `ins` in 32: instruction word (rs=[25:21], rt=[20:16], rd=[15:11])
- `npc_i` in DATA_W: PC+4 of `ins`
- `flush` in 1: squash the instruction in ID (taken branch/jump resolved downstream)
- `reg_write` in 1: WB write enable
- `write_reg` in REG_ADDR_W: WB destination
- `write_data` in DATA_W: WB data
- `id_stall` out 1: combinational; IF must hold PC and `ins` this cycle
- `out_valid` out 1: ID/EX slot holds a real instruction
- `if_reg_write`, `if_mem_read`, `if_mem_write` out 1 each: control signals
- `op`, `func` out 6 each: ins[31:26], ins[5:0]
- `data_a`, `data_b` out DATA_W: rs and rt operands
- `data_write_reg` out REG_ADDR_W: destination register
- `imm` out DATA_W: extended immediate
- `jpc` out 26: ins[25:0]
- `npc_o` out DATA_W: passed-through `npc_i`

## Operation
- Decode: when `op`=0 (R-type), wr=1 and dst=rd; ADDI, ADDIU, ANDI, ORI, XORI, LUI set wr=1, dst=rt; LW and LB set wr=1, rd_mem=1, dst=rt; SW and SB set wr_mem=1; BEQ, BNE, BGTZ and J set no enables; JAL sets wr=1, dst=`LINK_REG`. An unknown opcode decodes as a NOP: `out_valid`=1 with all enables 0. Any field without a meaningful value is forced to 0.
- Immediate: ADDI, ADDIU, loads, stores and branches sign-extend ins[15:0] to DATA_W. ANDI, ORI and XORI zero-extend. LUI gives {ins[15:0],16'b0}, then zero-extends.
- Source usage: rs is used by every opcode except J and JAL. rt is used only by R-type, BEQ, BNE, SW and SB.
- Hazard: `id_stall` = `in_valid` & !`flush` & `out_valid` & `if_mem_read` & (`data_write_reg`≠0) & (the slot's `data_write_reg` matches a used rs or rt).
- Register file: registers are written on the rising edge when `reg_write` is set and `write_reg`≠0. Writes to register 0 are ignored, so it always reads 0. A read whose index equals `write_reg` while `reg_write` is set (and index≠0) returns `write_data` (write-through bypass).

## Timing
- On each rising edge the ID/EX register loads as follows, highest priority first:
  - `flush`: bubble.
  - `id_stall`: bubble.
  - `!in_valid`: bubble.
  - otherwise: the decoded instruction with `out_valid`=1.
- Bubble: `out_valid` and all enables are 0; the data fields may hold any value.
- Latency: one cycle from `ins` to the EX outputs. The operands reflect register state including any same-cycle WB write.
- A load-use sequence costs exactly one stall cycle, after which the load has left the slot and `id_stall` drops.
- Reset (any time, including mid-stall): every output register and every file register clears to 0 asynchronously, and `id_stall` evaluates to 0.
- `flush` together with `id_stall` gives a bubble, and `id_stall` is forced to 0.

## Structure
- Shared package `cpu_pkg`: opcode and funct localparams (OP_SPECIAL, OP_ADDI, …, OP_JAL) and the extension-mode enum {EXT_SIGN, EXT_ZERO, EXT_UPPER}. The EX and MEM stages reuse both.
- Sub-module `regfile`: parametrised (`DATA_W`, `REG_ADDR_W`), two read ports and one write port, with bypass, async reset and register 0 hard-wired.
- The top level holds the decoder, hazard logic and ID/EX register.

## Test plan
- Reset release, then ADDI r1,r0,-5 (0x2001FFFB) → next cycle `out_valid`=1, `if_reg_write`=1, `data_write_reg`=1, `imm`=0xFFFFFFFB.
- ORI r2,r0,0x8001 → `imm`=0x00008001. LUI r3,0x1234 → `imm`=0x12340000.
- WB writes r5=0xDEADBEEF in the same cycle ID decodes ADD r6,r5,r0 → `data_a`=0xDEADBEEF. A write to r0 followed by a read of r0 → 0.
- LW r4,0(r1) followed by ADD r7,r4,r4 → `id_stall`=1 for one cycle and a bubble reaches EX; the ADD issues the next cycle. LW r4 followed by ADDI r4,r0,1 (rt not used as a source) → no stall.
- `flush` asserted during that stall cycle → bubble with `id_stall`=0. JAL → `data_write_reg`=31, `npc_o`=`npc_i`.
- Reset pulsed mid-stream → all outputs 0 immediately, and earlier register writes read back as 0.
